spi_ram_wrapper: RTL and testbench

- Self-contained SPI loopback subsystem: an SPI master, driven by a parallel 10-bit command port, talks over internal SPI wires (sclk, ss_n, MOSI, MISO) to an SPI slave that fronts a 256x8 RAM.
- Used as a monolithic test vehicle for the SPI master/slave pair.
- Host issues 2-bit-opcode commands; the block returns read data on data_out with a done pulse.

---
 rtl/spi_ram_pkg.sv | 36 +++
 rtl/spi_ram_wrapper_slave.sv | 172 +++++++++++++++++
 rtl/spi_ram_wrapper.sv | 175 +++++++++++++++++
 tb/tb_spi_ram_wrapper.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and defaults for the SPI loopback RAM subsystem.
// Opcodes, master/slave state encodings and the default field widths live here.
package spi_ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CMD_W  = 10;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        M_IDLE    = 3'd0,
        M_SEND    = 3'd1,
        M_WAIT_RD = 3'd2,
        M_RECV    = 3'd3,
        M_DONE    = 3'd4
    } mst_state_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHK_CMD = 2'd1,
        S_RX      = 2'd2,
        S_TX      = 2'd3
    } slv_state_e;

    // Opcode field of a received command word.
    function automatic opcode_e cmd_opcode(input logic [CMD_W-1:0] cmd);
        return opcode_e'(cmd[CMD_W-1 -: 2]);
    endfunction

endpackage

// File: rtl/spi_ram_wrapper_slave.sv
// SPI slave fronting a 2**ADDR_W x DATA_W RAM with write/read address registers.
// A command is shifted in MSB first on ss_n low; the command executes one cycle
// after its last bit (CHK_CMD). A read command answers with DATA_W bits on MISO.
// Optional macro SPI_ASSERT_EN enables embedded assertions.
module spi_ram_wrapper_slave
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W,
    parameter int CMD_W_P  = CMD_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic valid_miso,
    output logic sready
);

    localparam int DEPTH = 2 ** ADDR_W_P;

    slv_state_e                state_q, state_d;
    logic                      ss_prev_q;
    logic [CMD_W_P-2:0]        rx_shift_q, rx_shift_d;
    logic [3:0]                rx_cnt_q, rx_cnt_d;
    logic [CMD_W_P-1:0]        rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic [DATA_W_P-1:0]       tx_shift_q, tx_shift_d;
    logic [2:0]                tx_cnt_q, tx_cnt_d;
    logic                      miso_q, miso_d;
    logic                      valid_miso_q, valid_miso_d;
    logic [ADDR_W_P-1:0]       wr_addr_q, wr_addr_d;
    logic [ADDR_W_P-1:0]       rd_addr_q, rd_addr_d;
    logic [DATA_W_P-1:0]       ram_q [DEPTH];
    logic                      ram_we_s;
    logic [DATA_W_P-1:0]       ram_wdata_s;
    logic [DATA_W_P-1:0]       rd_word_s;

    assign rd_word_s  = ram_q[rd_addr_q];
    assign miso       = miso_q;
    assign valid_miso = valid_miso_q;
    assign sready     = (state_q == S_IDLE);

    // Slave next-state: receive command, execute it, optionally transmit read data.
    always_comb begin
        state_d      = state_q;
        rx_shift_d   = rx_shift_q;
        rx_cnt_d     = rx_cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_shift_d   = tx_shift_q;
        tx_cnt_d     = tx_cnt_q;
        miso_d       = miso_q;
        valid_miso_d = valid_miso_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        ram_we_s     = 1'b0;
        ram_wdata_s  = rx_data_q[DATA_W_P-1:0];
        case (state_q)
            S_IDLE: begin
                miso_d       = 1'b0;
                valid_miso_d = 1'b0;
                if (ss_prev_q && !ss_n) begin
                    // First command bit arrives together with the falling edge.
                    rx_shift_d = {rx_shift_q[CMD_W_P-3:0], mosi};
                    rx_cnt_d   = 4'd1;
                    state_d    = S_RX;
                end else begin
                    rx_cnt_d = 4'd0;
                end
            end
            S_RX: begin
                if (ss_n) begin
                    state_d = S_IDLE;
                end else begin
                    rx_shift_d = {rx_shift_q[CMD_W_P-3:0], mosi};
                    rx_cnt_d   = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'(CMD_W_P - 1)) begin
                        rx_data_d  = {rx_shift_q, mosi};
                        rx_valid_d = 1'b1;
                        state_d    = S_CHK_CMD;
                    end else begin
                        state_d = S_RX;
                    end
                end
            end
            S_CHK_CMD: begin
                // The command is already complete here, so it executes even if
                // the master has already raised ss_n.
                state_d = S_IDLE;
                if (rx_valid_q) begin
                    case (cmd_opcode(rx_data_q))
                        OP_WR_ADDR: wr_addr_d = rx_data_q[ADDR_W_P-1:0];
                        OP_WR_DATA: ram_we_s  = 1'b1;
                        OP_RD_ADDR: rd_addr_d = rx_data_q[ADDR_W_P-1:0];
                        OP_RD_DATA: begin
                            miso_d       = rd_word_s[DATA_W_P-1];
                            tx_shift_d   = {rd_word_s[DATA_W_P-2:0], 1'b0};
                            valid_miso_d = 1'b1;
                            tx_cnt_d     = 3'd0;
                            state_d      = S_TX;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TX: begin
                if (ss_n || (tx_cnt_q == 3'(DATA_W_P - 1))) begin
                    miso_d       = 1'b0;
                    valid_miso_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    miso_d     = tx_shift_q[DATA_W_P-1];
                    tx_shift_d = {tx_shift_q[DATA_W_P-2:0], 1'b0};
                    tx_cnt_d   = tx_cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slave state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ss_prev_q    <= 1'b1;
            rx_shift_q   <= '0;
            rx_cnt_q     <= 4'd0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_shift_q   <= '0;
            tx_cnt_q     <= 3'd0;
            miso_q       <= 1'b0;
            valid_miso_q <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            ss_prev_q    <= ss_n;
            rx_shift_q   <= rx_shift_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_shift_q   <= tx_shift_d;
            tx_cnt_q     <= tx_cnt_d;
            miso_q       <= miso_d;
            valid_miso_q <= valid_miso_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    // RAM array: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else if (ram_we_s) begin
            ram_q[wr_addr_q] <= ram_wdata_s;
        end
    end

`ifdef SPI_ASSERT_EN
    a_valid_miso_tx: assert property (@(posedge clk) disable iff (!rst_n)
        valid_miso_q |-> (state_q == S_TX));
`endif

endmodule

// File: rtl/spi_ram_wrapper.sv
// SPI loopback test vehicle: parallel command port -> SPI master -> SPI slave + RAM.
// The master FSM lives here; the slave and RAM are in spi_ram_wrapper_slave.
// Optional macro SPI_ASSERT_EN enables embedded protocol assertions.
module spi_ram_wrapper
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W,
    parameter int CMD_W_P  = CMD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CMD_W_P-1:0]  data_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [DATA_W_P-1:0] data_out
);

    mst_state_e           state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [CMD_W_P-2:0]   cmd_q, cmd_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_W_P-2:0]  rx_shift_q, rx_shift_d;
    logic                 ss_n_q, ss_n_d;
    logic                 mosi_q, mosi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATA_W_P-1:0]  data_out_q, data_out_d;
    logic [DATA_W_P-1:0]  rx_word_s;
    logic                 miso_s;
    logic                 valid_miso_s;
    logic                 sready_s;

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign rx_word_s = {rx_shift_q, miso_s};

    // Master next-state: capture, shift command out, optionally collect read data.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cmd_d      = cmd_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        ss_n_d     = ss_n_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        case (state_q)
            M_IDLE: begin
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    // MSB goes out right away; the rest is shifted from cmd_q.
                    op_d      = data_in[CMD_W_P-1 -: 2];
                    cmd_d     = data_in[CMD_W_P-2:0];
                    mosi_d    = data_in[CMD_W_P-1];
                    ss_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = M_SEND;
                end else begin
                    state_d = M_IDLE;
                end
            end
            M_SEND: begin
                if (bit_cnt_q == 4'(CMD_W_P - 1)) begin
                    mosi_d = 1'b0;
                    if (op_q == OP_RD_DATA) begin
                        state_d = M_WAIT_RD;
                    end else begin
                        ss_n_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = M_DONE;
                    end
                end else begin
                    mosi_d    = cmd_q[CMD_W_P-2];
                    cmd_d     = {cmd_q[CMD_W_P-3:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            M_WAIT_RD: begin
                // Turnaround cycle while the slave fetches the RAM word.
                bit_cnt_d = 4'd0;
                state_d   = M_RECV;
            end
            M_RECV: begin
                if (valid_miso_s) begin
                    rx_shift_d = rx_word_s[DATA_W_P-2:0];
                end else begin
                    rx_shift_d = rx_shift_q;
                end
                if (bit_cnt_q == 4'(DATA_W_P - 1)) begin
                    data_out_d = rx_word_s;
                    ss_n_d     = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = M_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            M_DONE: begin
                // Start is ignored during the done cycle.
                state_d = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
    end

    // Master state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= M_IDLE;
            op_q       <= 2'b00;
            cmd_q      <= '0;
            bit_cnt_q  <= 4'd0;
            rx_shift_q <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cmd_q      <= cmd_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    spi_ram_wrapper_slave #(
        .ADDR_W_P (ADDR_W_P),
        .DATA_W_P (DATA_W_P),
        .CMD_W_P  (CMD_W_P)
    ) u_slave (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n       (ss_n_q),
        .mosi       (mosi_q),
        .miso       (miso_s),
        .valid_miso (valid_miso_s),
        .sready     (sready_s)
    );

`ifdef SPI_ASSERT_EN
    a_ss_len_short: assert property (@(posedge clk) disable iff (!rst_n)
        ($fell(ss_n_q) && (op_q != OP_RD_DATA)) |-> (!ss_n_q) [*10] ##1 ss_n_q);
    a_ss_len_read: assert property (@(posedge clk) disable iff (!rst_n)
        ($fell(ss_n_q) && (op_q == OP_RD_DATA)) |-> (!ss_n_q) [*19] ##1 ss_n_q);
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        done_q |=> !done_q);
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(done_q && busy_q));
    a_start_ignored: assert property (@(posedge clk) disable iff (!rst_n)
        (busy_q && start) |=> $stable(op_q));
    a_sready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (!ss_n_q && busy_q && (state_q == M_SEND) && (bit_cnt_q > 4'd1)) |-> !sready_s);
`else
    logic unused_s;
    assign unused_s = sready_s;
`endif

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Scoreboard bench for spi_ram_wrapper: a reference model predicts read data,
// latencies and output holding; expectations are queued at issue and checked at done.
module tb_spi_ram_wrapper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] data_in;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] ref_mem [int];
    logic [7:0] m_wa;
    logic [7:0] m_ra;
    logic [7:0] last_rd;

    always #5 clk = ~clk;

    spi_ram_wrapper dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [7:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 8'h00;
    endfunction

    task automatic model(input logic [9:0] cmd);
        logic [7:0] v;
        case (cmd[9:8])
            2'b00: m_wa = cmd[7:0];
            2'b01: ref_mem[int'(m_wa)] = cmd[7:0];
            2'b10: m_ra = cmd[7:0];
            default: begin
                v = mem_rd(m_ra);
                exp_q.push_back(v);
                last_rd = v;
            end
        endcase
    endtask

    task automatic model_reset();
        ref_mem.delete();
        exp_q.delete();
        m_wa    = 8'h00;
        m_ra    = 8'h00;
        last_rd = 8'h00;
    endtask

    task automatic do_cmd(input logic [9:0] cmd, input bit poke);
        int lat;
        int extra;
        logic [7:0] e;
        model(cmd);
        @(negedge clk);
        data_in = cmd;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = 10'($urandom);
        lat     = 1;
        while (!done && lat < 40) begin
            if (poke && lat == 4) begin
                start   = 1'b1;
                data_in = 10'h3FF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("latency", lat, (cmd[9:8] == 2'b11) ? 32'd20 : 32'd11);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        if (cmd[9:8] == 2'b11) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            chk("rd_data", {24'd0, data_out}, {24'd0, e});
        end else begin
            chk("dout_hold", {24'd0, data_out}, {24'd0, last_rd});
        end
        if (poke) begin
            start   = 1'b1;
            data_in = 10'h3FF;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd0);
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 25; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) extra++;
            end
            chk("no_extra_txn", extra, 32'd0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 10'h000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dout", {24'd0, data_out}, 32'd0);
        chk("rst_ss_n", {31'd0, dut.ss_n_q}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read back.
        do_cmd(10'h0A5, 1'b0);
        do_cmd(10'h13C, 1'b0);
        do_cmd(10'h2A5, 1'b0);
        do_cmd(10'h300, 1'b0);

        // Overwrite address 00, exercise address FF.
        do_cmd(10'h000, 1'b0);
        do_cmd(10'h111, 1'b0);
        do_cmd(10'h122, 1'b0);
        do_cmd(10'h0FF, 1'b0);
        do_cmd(10'h15A, 1'b0);
        do_cmd(10'h200, 1'b0);
        do_cmd(10'h300, 1'b0);
        do_cmd(10'h2FF, 1'b0);
        do_cmd(10'h3C3, 1'b0);

        // Start pulses while busy and in the done cycle are ignored.
        do_cmd(10'h0A5, 1'b1);
        do_cmd(10'h2A5, 1'b1);
        do_cmd(10'h300, 1'b1);

        // Reset in the middle of an opcode-01 write to address 10.
        do_cmd(10'h010, 1'b0);
        @(negedge clk);
        data_in = 10'h177;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_dout", {24'd0, data_out}, 32'd0);
        chk("mid_rst_ss_n", {31'd0, dut.ss_n_q}, 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Default addresses are 0 after reset.
        do_cmd(10'h199, 1'b0);
        do_cmd(10'h300, 1'b0);
        do_cmd(10'h210, 1'b0);
        do_cmd(10'h3AB, 1'b0);

        // Randomised writes then reads over a small address window.
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 63));
            do_cmd({2'b00, a}, 1'b0);
            do_cmd({2'b01, 8'($urandom)}, 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom_range(0, 63));
            do_cmd({2'b10, a}, 1'b0);
            do_cmd({2'b11, 8'($urandom)}, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
